sigmoid_request_arbiter: RTL and testbench

SIGMOID_REQUEST_ARBITER -- requirements
Module: sigmoid_request_arbiter

---
 rtl/sigmoid_request_arbiter_if.sv | 41 ++++
 rtl/sigmoid_request_arbiter.sv | 124 ++++++++++++
 tb/tb_sigmoid_request_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_request_arbiter_if.sv
// Requester-side handshake and lookup-unit bus shared by sigmoid_request_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface sigmoid_request_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int Y_DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic [DATA_WIDTH-1:0]         lut_x_data_out;
  logic                          lut_read_out;
  logic [Y_DATA_WIDTH-1:0]       lut_y_data_in;
  logic                          lut_y_valid_in;
  logic [Y_DATA_WIDTH-1:0]       rsp_data_out;
  logic [NUM_REQ-1:0]            rsp_valid_out;

  modport slave (
    input  req_valid_in,
    input  req_data_in,
    input  lut_y_data_in,
    input  lut_y_valid_in,
    output req_ready_out,
    output lut_x_data_out,
    output lut_read_out,
    output rsp_data_out,
    output rsp_valid_out
  );

  modport master (
    output req_valid_in,
    output req_data_in,
    output lut_y_data_in,
    output lut_y_valid_in,
    input  req_ready_out,
    input  lut_x_data_out,
    input  lut_read_out,
    input  rsp_data_out,
    input  rsp_valid_out
  );
endinterface

// File: rtl/sigmoid_request_arbiter.sv
// Round-robin arbiter sharing one sigmoid lookup unit among NUM_REQ requesters,
// with credit limiting and an in-order ID FIFO to route results back.
module sigmoid_request_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int Y_DATA_WIDTH    = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  sigmoid_request_arbiter_if.slave arb,
  output logic                     busy_out,
  output logic                     error_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      rr_next;
  logic                  grant_found;
  logic                  can_issue;
  logic                  xfer;
  logic                  pop;
  logic                  underflow;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [IDX_W-1:0]      id_fifo [MAX_OUTSTANDING];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses only the registered count, so a returning result
  // never opens a slot in the same cycle.
  assign can_issue = !reset && (count < CNT_W'(MAX_OUTSTANDING));

  always_comb begin : rr_search
    logic [IDX_W:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && arb.req_valid_in[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (can_issue && grant_found) begin
      ready = NUM_REQ'(1) << grant_idx;
    end
  end

  assign arb.req_ready_out = ready;
  assign xfer       = |(ready & arb.req_valid_in);
  assign grant_data = arb.req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign rr_next    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // A result with nothing outstanding is a protocol error and is dropped.
  assign pop       = arb.lut_y_valid_in && (count != '0);
  assign underflow = arb.lut_y_valid_in && (count == '0);
  assign busy_out  = (count != '0);

  always_ff @(posedge clk) begin
    if (xfer) begin
      id_fifo[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr             <= '0;
      count              <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      arb.lut_read_out   <= 1'b0;
      arb.lut_x_data_out <= '0;
      arb.rsp_valid_out  <= '0;
      arb.rsp_data_out   <= '0;
      error_out          <= 1'b0;
    end else begin
      if (xfer) begin
        rr_ptr <= rr_next;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({xfer, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      arb.lut_read_out <= xfer;
      if (xfer) begin
        arb.lut_x_data_out <= grant_data;
      end

      arb.rsp_valid_out <= pop ? (NUM_REQ'(1) << id_fifo[rd_ptr]) : '0;
      if (pop) begin
        arb.rsp_data_out <= arb.lut_y_data_in;
      end

      if (underflow) begin
        error_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_request_arbiter.sv
// Randomized bench for sigmoid_request_arbiter with a queue-based reference model
// and a simple in-order lookup-unit model with variable latency.
module tb_sigmoid_request_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int YW = 16;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy_out;
  logic error_out;

  sigmoid_request_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .Y_DATA_WIDTH(YW)) bus ();

  sigmoid_request_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .Y_DATA_WIDTH(YW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arb       (bus),
    .busy_out  (busy_out),
    .error_out (error_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  int              m_rr;
  bit              m_err;
  bit              m_read;
  logic [DW-1:0]   m_x;
  logic [N-1:0]    m_rsp_valid;
  logic [YW-1:0]   m_rsp_data;
  int              m_id_q[$];

  // lookup unit model
  int              lut_due_q[$];
  logic [YW-1:0]   lut_val_q[$];
  int              lut_last_due = -1;
  int              lut_credit   = -1;
  int              lat_min      = 2;
  int              lat_max      = 2;
  bit              inj_yv       = 1'b0;

  logic [N-1:0]    st_valid = '0;
  logic [N*DW-1:0] st_data  = '0;

  int              dut_gl[$];
  int              dut_gc[$];
  logic [N-1:0]    dut_rsp[$];
  int              r_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int m_grant();
    if (reset || m_id_q.size() >= MO) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (st_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    int           g;
    int           d;
    bit           yv;
    logic [YW-1:0] yd;
    logic [N-1:0] exp_rdy;
    yv = 1'b0;
    yd = '0;
    if (lut_credit != 0 && lut_due_q.size() > 0 && lut_due_q[0] <= cyc) begin
      yv = 1'b1;
      void'(lut_due_q.pop_front());
      yd = lut_val_q.pop_front();
      if (lut_credit > 0) lut_credit--;
    end
    if (inj_yv) begin
      yv = 1'b1;
      yd = 16'hdead;
    end
    bus.lut_y_valid_in = yv;
    bus.lut_y_data_in  = yd;
    bus.req_valid_in   = st_valid;
    bus.req_data_in    = st_data;
    #1;
    g = m_grant();
    exp_rdy = (g < 0) ? '0 : (N'(1) << g);
    chk("req_ready", 64'(bus.req_ready_out), 64'(exp_rdy));
    for (int k = 0; k < N; k++) begin
      if (bus.req_ready_out[k] && bus.req_valid_in[k]) begin
        dut_gl.push_back(k);
        dut_gc.push_back(cyc);
      end
    end

    @(posedge clk);
    cyc++;
    if (reset) begin
      m_id_q.delete();
      m_rr = 0; m_err = 1'b0; m_read = 1'b0; m_x = '0;
      m_rsp_valid = '0; m_rsp_data = '0;
    end else begin
      m_read = 1'b0;
      m_rsp_valid = '0;
      if (yv) begin
        if (m_id_q.size() > 0) begin
          m_rsp_valid = N'(1) << m_id_q.pop_front();
          m_rsp_data  = yd;
        end else begin
          m_err = 1'b1;
        end
      end
      if (g >= 0) begin
        m_id_q.push_back(g);
        m_read = 1'b1;
        m_x    = st_data[g*DW +: DW];
        m_rr   = (g + 1) % N;
      end
    end

    @(negedge clk);
    chk("lut_read",  64'(bus.lut_read_out),   64'(m_read));
    chk("lut_x",     64'(bus.lut_x_data_out), 64'(m_x));
    chk("rsp_valid", 64'(bus.rsp_valid_out),  64'(m_rsp_valid));
    chk("rsp_data",  64'(bus.rsp_data_out),   64'(m_rsp_data));
    chk("busy",      64'(busy_out),           64'(m_id_q.size() != 0));
    chk("error",     64'(error_out),          64'(m_err));
    if (|bus.rsp_valid_out) dut_rsp.push_back(bus.rsp_valid_out);
    if (bus.lut_read_out === 1'b1) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= lut_last_due) d = lut_last_due + 1;
      lut_due_q.push_back(d);
      lut_val_q.push_back(bus.lut_x_data_out ^ 16'h6100);
      lut_last_due = d;
    end
  endtask

  initial begin
    reset = 1'b1;
    step(); step();
    chk("rst_busy",  64'(busy_out), 64'(0));
    chk("rst_error", 64'(error_out), 64'(0));
    chk("rst_x",     64'(bus.lut_x_data_out), 64'(0));
    reset = 1'b0;

    // single request, lookup latency 2
    st_valid = 4'b0001;
    st_data  = 64'h0;
    st_data[15:0] = 16'h0100;
    step();
    st_valid = '0;
    chk("single_read", 64'(bus.lut_read_out), 64'(1));
    chk("single_x",    64'(bus.lut_x_data_out), 64'(16'h0100));
    step(); step(); step();
    chk("single_rsp_valid", 64'(bus.rsp_valid_out), 64'(4'b0001));
    chk("single_rsp_data",  64'(bus.rsp_data_out), 64'(16'h6000));

    // all valid, results withheld
    reset = 1'b1; step(); reset = 1'b0;
    lut_credit = 0;
    st_valid = 4'b1111;
    st_data  = {$urandom(), $urandom()};
    dut_gl.delete(); dut_gc.delete();
    repeat (10) step();
    chk("sat_grant_count", 64'(dut_gl.size()), 64'(4));
    if (dut_gl.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("sat_grant_order", 64'(dut_gl[i]), 64'(i));
    end
    chk("sat_ready", 64'(bus.req_ready_out), 64'(0));
    chk("sat_busy",  64'(busy_out), 64'(1));

    // release exactly one result
    dut_gl.delete(); dut_gc.delete();
    lut_credit = 1;
    r_cyc = cyc;
    step();
    repeat (6) step();
    chk("credit_one_grant", 64'(dut_gl.size()), 64'(1));
    if (dut_gc.size() >= 1) chk("credit_grant_cycle", 64'(dut_gc[0]), 64'(r_cyc + 1));
    lut_credit = -1;
    st_valid = '0;
    repeat (15) step();

    // in-order routing 2,0,3
    dut_rsp.delete();
    st_valid = 4'b0100; step();
    st_valid = 4'b0001; step();
    st_valid = 4'b1000; step();
    st_valid = '0;
    repeat (8) step();
    chk("order_count", 64'(dut_rsp.size()), 64'(3));
    if (dut_rsp.size() >= 3) begin
      chk("order_0", 64'(dut_rsp[0]), 64'(4'b0100));
      chk("order_1", 64'(dut_rsp[1]), 64'(4'b0001));
      chk("order_2", 64'(dut_rsp[2]), 64'(4'b1000));
    end

    // spurious result with nothing outstanding
    inj_yv = 1'b1; step(); inj_yv = 1'b0;
    chk("spur_error", 64'(error_out), 64'(1));
    chk("spur_rsp",   64'(bus.rsp_valid_out), 64'(0));
    chk("spur_busy",  64'(busy_out), 64'(0));
    repeat (3) step();
    chk("spur_sticky", 64'(error_out), 64'(1));

    // reset with three outstanding
    reset = 1'b1; step(); reset = 1'b0;
    lut_credit = 0;
    st_valid = 4'b0111;
    repeat (3) step();
    chk("pre_rst_busy", 64'(busy_out), 64'(1));
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_busy",  64'(busy_out), 64'(0));
    chk("mid_rst_read",  64'(bus.lut_read_out), 64'(0));
    chk("mid_rst_rsp",   64'(bus.rsp_valid_out), 64'(0));
    chk("mid_rst_error", 64'(error_out), 64'(0));
    lut_due_q.delete(); lut_val_q.delete();
    st_valid = 4'b1111;
    dut_gl.delete(); dut_gc.delete();
    step();
    chk("post_rst_count", 64'(dut_gl.size()), 64'(1));
    if (dut_gl.size() >= 1) chk("post_rst_first", 64'(dut_gl[0]), 64'(0));
    st_valid = '0;
    lut_credit = -1;
    repeat (10) step();

    // randomized traffic
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 1500; i++) begin
      st_valid = ($urandom_range(3, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 0));
      st_data  = {$urandom(), $urandom()};
      if ($urandom_range(19, 0) == 0) lut_credit = (lut_credit == 0) ? -1 : 0;
      reset = (i == 700);
      step();
    end
    reset = 1'b0;
    lut_credit = -1;
    st_valid = '0;
    repeat (40) step();
    chk("drain_busy", 64'(busy_out), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
